temp_monitor: RTL and testbench
===============================

Name: temp_monitor

Overview:
Samples a 10-bit temperature stream qualified by a valid strobe and drives three status indicators: fan control, alarm and overheat LED. The fan uses a hysteresis comparator. The alarm requires the threshold to persist over consecutive samples. Overheat is a sticky latch. Sits between the temperature sensor/ADC interface and the board-level fan driver and status LEDs.

Parameters:
W, 10, temperature data width
FAN_ON_TH, 500, fan turns on at sample >= this
FAN_OFF_TH, 480, fan turns off at sample < this (must be <= FAN_ON_TH)
ALARM_TH, 750, alarm-qualifying sample >= this
ALARM_CLR_TH, 720, alarm clears at sample < this
ALARM_PERSIST, 3, consecutive qualifying valid samples required to raise alarm (>=1)
OVERHEAT_TH, 850, overheat latch sets at sample >= this

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
temp_in  input  W  unsigned temperature sample
temp_valid  input  1  temp_in is valid this cycle
temp_out  output  W  last accepted (or filtered) sample, registered
alarm  output  1  persistent high-temperature alarm
fan_on  output  1  fan enable
overheat_led  output  1  sticky overheat indicator

Behaviour:
- Reset (rst=0, asynchronous): temp_out=0, alarm=0, fan_on=0, overheat_led=0, persistence counter=0. Internal state is held in reset while rst=0.
- All outputs are registered. Each sample has 1-clock latency: the edge that accepts temp_valid=1 also updates temp_out and every flag, decided from the effective sample S.
- S = temp_in (or the filtered value; see Optional Feature).
- temp_valid=0: all registers hold. The persistence counter does not reset on gaps.
- fan_on:
  - Set when S >= FAN_ON_TH.
  - Cleared when S < FAN_OFF_TH.
  - Otherwise hold.
  - Forced to 1 whenever overheat_led=1.
- alarm (persistence counter saturates at ALARM_PERSIST):
  - S >= ALARM_TH: counter increments; alarm=1 when the incremented count reaches ALARM_PERSIST.
  - S < ALARM_TH: counter cleared.
  - S < ALARM_CLR_TH: alarm cleared.
  - ALARM_CLR_TH <= S < ALARM_TH: alarm holds.
- overheat_led: set on any S >= OVERHEAT_TH. Cleared only by reset.
- Comparisons are unsigned, full W bits, and inclusive exactly as stated. Value 1023 requires no special handling.
- Reset mid-operation: outputs go to 0 immediately (asynchronously), regardless of clk. The first valid sample after reset release is processed normally.
- temp_in changes while temp_valid=0 have no effect.

Optional Feature:
Macro TEMP_AVG_EN.
- Defined: S is the 4-sample moving average of accepted samples, computed as (sum of last 4) >> 2 using a W+2-bit sum and truncated. The first valid sample after reset fills all 4 window entries. temp_out = S.
- Undefined: S = temp_in and no window logic is present.
- Latency stays 1 clock in both cases.

Decomposition:
- Package temp_monitor_pkg holds the temperature typedef (W-bit unsigned) and the default threshold constants.
- One natural sub-module, temp_hyst_cmp: a registered set/clear hysteresis comparator with parameters SET_TH and CLR_TH. It is instantiated for fan_on and used for the alarm clear/hold path.
- The persistence counter, overheat latch and optional averager live in the top module.

Test Plan:
- Reset asserted, then released with no valid samples -> all outputs 0, temp_out=0.
- temp_valid=1, temp_in=400 -> temp_out=400 after 1 clk; fan_on=0, alarm=0, overheat_led=0.
- Reset pulse, then temp_in=550 valid -> temp_out=550, fan_on=1, alarm=0, overheat_led=0.
  - Then 490 -> fan stays 1; then 470 -> fan_on=0.
- Reset pulse, then temp_in=900 held valid -> first edge: temp_out=900, overheat_led=1, fan_on=1, alarm=0; third valid edge: alarm=1.
  - Then 400 -> alarm=0, overheat_led and fan_on stay 1.
- Alarm persistence: 760, 760, 700, 760, 760 valid -> alarm never asserts (counter cleared by 700). Inserting temp_valid=0 gaps between three 760s -> alarm asserts on the 3rd valid sample.
- Async reset: rst=0 mid-cycle while overheat_led=1 -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/temp_monitor_pkg.sv
// Shared types and default thresholds for the temperature monitor.
// Datapath width and trip points are collected here so the top and sub-module agree.
package temp_monitor_pkg;

    localparam int unsigned TempW = 10;

    typedef logic [TempW-1:0] temp_t;

    localparam int unsigned DefFanOnTh     = 500;
    localparam int unsigned DefFanOffTh    = 480;
    localparam int unsigned DefAlarmTh     = 750;
    localparam int unsigned DefAlarmClrTh  = 720;
    localparam int unsigned DefAlarmPersist = 3;
    localparam int unsigned DefOverheatTh  = 850;

endpackage

// File: rtl/temp_hyst_cmp.sv
// Registered set/clear hysteresis comparator updated only on valid samples.
// set_en_i qualifies the set path; force_i pins the state high on a valid sample.
module temp_hyst_cmp
    import temp_monitor_pkg::*;
#(
    parameter int unsigned W      = TempW,
    parameter int unsigned SET_TH = DefFanOnTh,
    parameter int unsigned CLR_TH = DefFanOffTh
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    input  logic [W-1:0] value_i,
    input  logic         set_en_i,
    input  logic         force_i,
    output logic         state_o
);

    localparam logic [W-1:0] SetTh = W'(SET_TH);
    localparam logic [W-1:0] ClrTh = W'(CLR_TH);

    logic state_d, state_q;

    // Between the thresholds, or above SET_TH without qualification, the state holds.
    always_comb begin
        state_d = state_q;
        if (valid_i) begin
            if (force_i || (set_en_i && (value_i >= SetTh))) begin
                state_d = 1'b1;
            end else if (value_i < ClrTh) begin
                state_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/temp_monitor.sv
// Temperature monitor: hysteretic fan control, persistent alarm, sticky overheat LED.
// Define TEMP_AVG_EN to decide on a 4-sample moving average instead of the raw sample.
module temp_monitor
    import temp_monitor_pkg::*;
#(
    parameter int unsigned W             = TempW,
    parameter int unsigned FAN_ON_TH     = DefFanOnTh,
    parameter int unsigned FAN_OFF_TH    = DefFanOffTh,
    parameter int unsigned ALARM_TH      = DefAlarmTh,
    parameter int unsigned ALARM_CLR_TH  = DefAlarmClrTh,
    parameter int unsigned ALARM_PERSIST = DefAlarmPersist,
    parameter int unsigned OVERHEAT_TH   = DefOverheatTh
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] temp_in,
    input  logic         temp_valid,
    output logic [W-1:0] temp_out,
    output logic         alarm,
    output logic         fan_on,
    output logic         overheat_led
);

    localparam int unsigned      CntW       = $clog2(ALARM_PERSIST + 1);
    localparam logic [CntW-1:0]  PersistMax = CntW'(ALARM_PERSIST);
    localparam logic [W-1:0]     AlarmTh    = W'(ALARM_TH);
    localparam logic [W-1:0]     OvhTh      = W'(OVERHEAT_TH);

    logic [W-1:0] sample;

`ifdef TEMP_AVG_EN
    // Three most recent accepted samples; the incoming one is the fourth window entry.
    logic [W-1:0] win_q [3];
    logic [W-1:0] win_d [3];
    logic         filled_d, filled_q;
    logic [W+1:0] sum;

    always_comb begin
        win_d    = win_q;
        filled_d = filled_q;
        if (!filled_q) begin
            sum = {temp_in, 2'b00};
        end else begin
            sum = {2'b00, win_q[0]} + {2'b00, win_q[1]} + {2'b00, win_q[2]}
                + {2'b00, temp_in};
        end
        if (temp_valid) begin
            filled_d = 1'b1;
            if (!filled_q) begin
                win_d[0] = temp_in;
                win_d[1] = temp_in;
                win_d[2] = temp_in;
            end else begin
                win_d[2] = win_q[1];
                win_d[1] = win_q[0];
                win_d[0] = temp_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filled_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            filled_q <= filled_d;
            win_q    <= win_d;
        end
    end

    assign sample = sum[W+1:2];
`else
    assign sample = temp_in;
`endif

    logic [W-1:0]    temp_out_d, temp_out_q;
    logic [CntW-1:0] cnt_d, cnt_q, cnt_inc;
    logic            ovh_d, ovh_q;
    logic            alarm_set_en;

    always_comb begin
        temp_out_d   = temp_out_q;
        cnt_d        = cnt_q;
        ovh_d        = ovh_q;
        cnt_inc      = (cnt_q == PersistMax) ? cnt_q : cnt_q + 1'b1;
        alarm_set_en = (cnt_inc == PersistMax);
        if (temp_valid) begin
            temp_out_d = sample;
            cnt_d      = (sample >= AlarmTh) ? cnt_inc : '0;
            if (sample >= OvhTh) begin
                ovh_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            temp_out_q <= '0;
            cnt_q      <= '0;
            ovh_q      <= 1'b0;
        end else begin
            temp_out_q <= temp_out_d;
            cnt_q      <= cnt_d;
            ovh_q      <= ovh_d;
        end
    end

    // Overheat (new or already latched) forces the fan on in the same cycle it is decided.
    temp_hyst_cmp #(
        .W      (W),
        .SET_TH (FAN_ON_TH),
        .CLR_TH (FAN_OFF_TH)
    ) u_fan_cmp (
        .clk_i    (clk),
        .rst_ni   (rst),
        .valid_i  (temp_valid),
        .value_i  (sample),
        .set_en_i (1'b1),
        .force_i  (ovh_d),
        .state_o  (fan_on)
    );

    temp_hyst_cmp #(
        .W      (W),
        .SET_TH (ALARM_TH),
        .CLR_TH (ALARM_CLR_TH)
    ) u_alarm_cmp (
        .clk_i    (clk),
        .rst_ni   (rst),
        .valid_i  (temp_valid),
        .value_i  (sample),
        .set_en_i (alarm_set_en),
        .force_i  (1'b0),
        .state_o  (alarm)
    );

    assign temp_out     = temp_out_q;
    assign overheat_led = ovh_q;

endmodule

// File: tb/tb_temp_monitor.sv
// Scoreboard bench for temp_monitor (default build, raw sample decisions).
module tb_temp_monitor;
    import temp_monitor_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    temp_t temp_in = '0;
    logic  temp_valid = 1'b0;
    temp_t temp_out;
    logic  alarm, fan_on, overheat_led;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        int    t;
        bit    a;
        bit    f;
        bit    o;
    } exp_t;

    exp_t exp_q[$];

    temp_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .temp_in      (temp_in),
        .temp_valid   (temp_valid),
        .temp_out     (temp_out),
        .alarm        (alarm),
        .fan_on       (fan_on),
        .overheat_led (overheat_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each accepted sample is compared 1 ns after the edge that takes it.
    always @(posedge clk) begin
        if (rst && temp_valid) begin
            #1;
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, ".temp_out"}, int'(temp_out), e.t);
                chk({e.name, ".alarm"}, int'(alarm), int'(e.a));
                chk({e.name, ".fan_on"}, int'(fan_on), int'(e.f));
                chk({e.name, ".overheat"}, int'(overheat_led), int'(e.o));
            end
        end
    end

    task automatic send(input string name, input int t, input bit a, input bit f, input bit o);
        exp_t e;
        @(negedge clk);
        temp_in    = temp_t'(t);
        temp_valid = 1'b1;
        e.name = name; e.t = t; e.a = a; e.f = f; e.o = o;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input int junk);
        @(negedge clk);
        temp_valid = 1'b0;
        temp_in    = temp_t'(junk);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        temp_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_state(input string name, input int t, input bit a, input bit f,
                             input bit o);
        chk({name, ".temp_out"}, int'(temp_out), t);
        chk({name, ".alarm"}, int'(alarm), int'(a));
        chk({name, ".fan_on"}, int'(fan_on), int'(f));
        chk({name, ".overheat"}, int'(overheat_led), int'(o));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(3, 0);
        chk_state("reset_idle", 0, 0, 0, 0);

        send("cool_400", 400, 0, 0, 0);
        do_reset();

        send("fan_550", 550, 0, 1, 0);
        send("fan_490_hold", 490, 0, 1, 0);
        send("fan_470_off", 470, 0, 0, 0);
        do_reset();

        send("hot_900_1", 900, 0, 1, 1);
        send("hot_900_2", 900, 0, 1, 1);
        send("hot_900_3", 900, 1, 1, 1);
        send("hot_then_400", 400, 0, 1, 1);
        do_reset();

        send("p_760_a", 760, 0, 1, 0);
        send("p_760_b", 760, 0, 1, 0);
        send("p_700", 700, 0, 1, 0);
        send("p_760_c", 760, 0, 1, 0);
        send("p_760_d", 760, 0, 1, 0);
        do_reset();

        send("gap_760_1", 760, 0, 1, 0);
        idle(2, 900);
        chk_state("gap_hold", 760, 0, 1, 0);
        send("gap_760_2", 760, 0, 1, 0);
        idle(3, 1000);
        send("gap_760_3", 760, 1, 1, 0);
        send("clr_730_hold", 730, 1, 1, 0);
        send("clr_760_hold", 760, 1, 1, 0);
        send("clr_719", 719, 0, 1, 0);
        do_reset();

        send("b_499", 499, 0, 0, 0);
        send("b_500", 500, 0, 1, 0);
        send("b_480", 480, 0, 1, 0);
        send("b_479", 479, 0, 0, 0);
        send("b_849", 849, 0, 1, 0);
        send("b_850", 850, 0, 1, 1);
        send("b_1023", 1023, 1, 1, 1);
        send("b_0_sticky", 0, 0, 1, 1);
        idle(1, 0);

        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_state("async_rst", 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send("post_rst_400", 400, 0, 0, 0);
        idle(3, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
